dma_mem_bridge: RTL
===================

# dma_mem_bridge

Memory-side bridge directly downstream of the DMA engine core. It accepts the engine's burst read and burst write requests (address plus length, valid/ready) and arbitrates between them. Each burst is serialised into single-beat accesses on one simple memory port, with only one access outstanding at a time. It returns read beats to the engine and consumes the engine's write beats, using the same channel handshakes the engine drives.

## Interface
- DATA_WIDTH, 32, beat width; only 32 is supported.

- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rd_req_addr  input  32  read burst start byte address
- rd_req_len  input  5  read beats minus one
- rd_req_valid  input  1  read burst request
- rd_req_ready  output  1  read request accepted
- rd_rdata  output  32  read beat data
- rd_valid  output  1  read beat valid
- rd_last  output  1  final read beat
- rd_ready  input  1  engine accepts read beat
- wr_req_addr  input  32  write burst start byte address
- wr_req_len  input  5  write beats minus one
- wr_req_valid  input  1  write burst request
- wr_req_ready  output  1  write request accepted
- wr_data  input  32  write beat data
- wr_valid  input  1  write beat valid
- wr_last  input  1  engine marks final beat
- wr_ready  output  1  bridge accepts write beat
- mem_addr  output  32  memory word address (byte address)
- mem_we  output  1  1 = write, 0 = read
- mem_wdata  output  32  write data
- mem_req_valid  output  1  memory access request
- mem_req_ready  input  1  memory accepts request
- mem_rdata  input  32  read return data
- mem_rvalid  input  1  single-cycle read return pulse
- err  output  1  sticky protocol error (see Configuration)

## Operation
- FSM states: IDLE, RD_ADDR, RD_WAIT, RD_BEAT, WR_DATA, WR_ISSUE.
- Arbitration in IDLE:
  - Only one of rd_req_valid / wr_req_valid high: that request is granted.
  - Both high: the grant goes to the channel that was not granted last.
  - The last-grant flag resets to "read", so the first tie goes to write.
- Grant behaviour:
  - rd_req_ready / wr_req_ready are combinational and high only in IDLE for the granted channel.
  - At grant, the bridge latches the address into cur_addr and the length into cur_len, and clears the 5-bit beat counter.
- Read path:
  - Grant → RD_ADDR.
  - RD_ADDR: mem_req_valid=1, mem_we=0, mem_addr=cur_addr. When mem_req_ready is high → RD_WAIT.
  - RD_WAIT: on mem_rvalid, capture mem_rdata into the beat register → RD_BEAT.
  - RD_BEAT: rd_valid=1, rd_rdata=beat register, rd_last=(beat==cur_len). rd_valid, rd_rdata and rd_last are held stable until rd_ready.
  - On rd_ready: if the beat was last → IDLE; otherwise beat+1, cur_addr+4 → RD_ADDR.
- Write path:
  - Grant → WR_DATA.
  - WR_DATA: wr_ready=1. When wr_valid is high, capture wr_data → WR_ISSUE.
  - WR_ISSUE: mem_req_valid=1, mem_we=1, mem_addr=cur_addr, mem_wdata=captured data.
  - On mem_req_ready: if beat==cur_len → IDLE; otherwise beat+1, cur_addr+4 → WR_DATA.
  - Writes are posted; there is no response.
- Address arithmetic is modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x0.
- rd_ready outside RD_BEAT, wr_valid outside WR_DATA, and mem_rvalid outside RD_WAIT are all ignored.
- Memory contract: mem_rvalid arrives at least one cycle after read acceptance, exactly once per read.

## Timing
- Reset values:
  - state=IDLE, last-grant=read, beat=0, cur_addr=0, err=0.
  - rd_valid, rd_last, wr_ready, mem_req_valid, mem_we are all 0.
  - rd_rdata, mem_addr, mem_wdata are all 0.
- Read beat, best case (memory ready, 1-cycle return):
  - Grant at T0, mem request at T1, mem_rvalid at T2, rd_valid at T3.
  - Subsequent beats take 3 cycles each with rd_ready held high.
- Write beat, best case: wr_ready at T1 after the grant cycle T0, mem request at T2, next wr_ready at T3. That is 2 cycles per beat.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. The burst is discarded and no further mem requests are issued.
- A new grant occurs no earlier than the cycle after returning to IDLE.

## Configuration
- DMA_BRIDGE_CHK_EN defined: err is set and held until rst when either of these occurs:
  - wr_last disagrees with (beat==cur_len) on an accepted write beat;
  - a granted request address has addr[1:0]!=0.
- Data flow is unchanged by the checks.
- DMA_BRIDGE_CHK_EN undefined: err is constant 0 and no check logic is built.

## Test plan
- Read burst:
  - Stimulus: addr 0x1000, len 7; memory returns data=address; rd_ready high.
  - Response: mem reads at 0x1000…0x101C; 8 rd_valid beats with data 0x1000…0x101C; rd_last only on the 8th; back in IDLE after.
- Write burst:
  - Stimulus: addr 0x2000, len 7, data 0xA0…0xA7, wr_last on the 8th beat.
  - Response: 8 mem writes with mem_we=1 at 0x2000…0x201C carrying 0xA0…0xA7; err=0.
- Arbitration:
  - Stimulus: read and write both valid after reset.
  - Response: write granted first. On the next tie, read is granted. The third tie is write.
- Backpressure:
  - Stimulus: rd_ready low for 5 cycles at beat 3; mem_req_ready low for 4 cycles on a write.
  - Response: rd_valid and data stable with no new mem request during the stall; mem_addr and mem_wdata stable during the write stall.
- Wrap and reset:
  - Stimulus: read at 0xFFFFFFF8, len 3.
  - Response: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - Stimulus: rst asserted during beat 2.
  - Response: IDLE next cycle, no further mem_req_valid.
- Checks:
  - Stimulus: with DMA_BRIDGE_CHK_EN, wr_last asserted on beat 5 of a len=7 burst.
  - Response: err=1 and sticky until rst. The same stimulus without the macro gives err=0.

Source files
------------

// File: rtl/dma_mem_bridge.sv
// rtl/dma_mem_bridge.sv - DMA engine to single-port memory burst bridge
//
// Takes burst read/write requests (start byte address, beats minus one)
// from the DMA engine, arbitrates between them, and serialises each burst
// into single-beat accesses on one memory port. Only one memory access is
// outstanding at a time.
//
// Optional feature macro: DMA_BRIDGE_CHK_EN
//   defined   : err latches on a misaligned granted address or on a write
//               beat whose wr_last disagrees with the burst length; cleared
//               only by rst.
//   undefined : err is tied to 0 and no check logic exists.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rd_req_addr/len/valid/ready read burst request channel
//   rd_rdata/valid/last/ready   read beat return channel
//   wr_req_addr/len/valid/ready write burst request channel
//   wr_data/valid/last/ready    write beat channel
//   mem_addr/we/wdata           memory access (byte address, 1 = write)
//   mem_req_valid/ready         memory request handshake
//   mem_rdata/rvalid            memory read return (single-cycle pulse)
//   err                         sticky protocol error

module dma_mem_bridge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           rd_req_addr,
  input  logic [4:0]            rd_req_len,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  input  logic [31:0]           wr_req_addr,
  input  logic [4:0]            wr_req_len,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RD_BEAT,
    WR_DATA,
    WR_ISSUE
  } state_t;

  state_t      state;
  logic        last_wr;    // 1 = previous grant went to write
  logic [31:0] cur_addr;
  logic [4:0]  cur_len;
  logic [4:0]  beat;

  logic        grant_rd;
  logic        grant_wr;
  logic        beat_is_last;
  logic [31:0] next_addr;

  // On a tie the channel not served last wins; last_wr resets to read so
  // the very first tie goes to write.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      grant_wr = wr_req_valid && (!rd_req_valid || !last_wr);
      grant_rd = rd_req_valid && !grant_wr;
    end
  end

  assign rd_req_ready = grant_rd;
  assign wr_req_ready = grant_wr;

  assign beat_is_last = (beat == cur_len);
  // Byte address step wraps naturally at 2^32.
  assign next_addr    = cur_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_wr       <= 1'b0;
      cur_addr      <= 32'd0;
      cur_len       <= 5'd0;
      beat          <= 5'd0;
      rd_rdata      <= '0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      wr_ready      <= 1'b0;
      mem_addr      <= 32'd0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_req_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state    <= WR_DATA;
            last_wr  <= 1'b1;
            cur_addr <= wr_req_addr;
            cur_len  <= wr_req_len;
            beat     <= 5'd0;
            wr_ready <= 1'b1;
          end else if (grant_rd) begin
            state         <= RD_ADDR;
            last_wr       <= 1'b0;
            cur_addr      <= rd_req_addr;
            cur_len       <= rd_req_len;
            beat          <= 5'd0;
            mem_addr      <= rd_req_addr;
            mem_we        <= 1'b0;
            mem_req_valid <= 1'b1;
          end
        end

        RD_ADDR: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_rvalid) begin
            rd_rdata <= mem_rdata;
            rd_valid <= 1'b1;
            rd_last  <= beat_is_last;
            state    <= RD_BEAT;
          end
        end

        // Beat outputs stay frozen until the engine takes them.
        RD_BEAT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (beat_is_last) begin
              state <= IDLE;
            end else begin
              beat          <= beat + 5'd1;
              cur_addr      <= next_addr;
              mem_addr      <= next_addr;
              mem_we        <= 1'b0;
              mem_req_valid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        WR_DATA: begin
          if (wr_valid) begin
            mem_wdata     <= wr_data;
            mem_addr      <= cur_addr;
            mem_we        <= 1'b1;
            mem_req_valid <= 1'b1;
            wr_ready      <= 1'b0;
            state         <= WR_ISSUE;
          end
        end

        // Writes are posted: acceptance by memory completes the beat.
        WR_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            if (beat_is_last) begin
              state <= IDLE;
            end else begin
              beat     <= beat + 5'd1;
              cur_addr <= next_addr;
              wr_ready <= 1'b1;
              state    <= WR_DATA;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DMA_BRIDGE_CHK_EN
  logic err_q;
  logic wr_last_bad;
  logic addr_bad;

  assign wr_last_bad = (state == WR_DATA) && wr_valid && (wr_last != beat_is_last);
  assign addr_bad    = (grant_wr && (wr_req_addr[1:0] != 2'b00)) ||
                       (grant_rd && (rd_req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_last_bad || addr_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // wr_last only feeds the protocol check; keep it visibly consumed.
  logic unused_wr_last;
  assign unused_wr_last = wr_last;
  assign err            = 1'b0;
`endif

endmodule
